// File: rtl/uart_rx_core_pkg.sv
// Shared UART receive types: parity/state enums, latched frame config.
// cfg_clamp() folds raw config inputs into the legal latched form.
package uart_rx_core_pkg;

  localparam int UART_DATA_WIDTH_MAX = 9;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    EVEN = 2'b01,
    ODD  = 2'b10
  } uart_parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_rx_state_e;

  typedef struct packed {
    logic [3:0]   data_bits;
    uart_parity_e parity;
    logic         stop_bits;
  } uart_rx_cfg_t;

  function automatic uart_rx_cfg_t cfg_clamp(
    input logic [3:0] bits,
    input logic [1:0] mode,
    input logic       stop,
    input int         wmax
  );
    uart_rx_cfg_t c;
    if (bits < 4'd5)
      c.data_bits = 4'd5;
    else if (int'(bits) > wmax)
      c.data_bits = 4'(wmax);
    else
      c.data_bits = bits;
    case (mode)
      2'b01:   c.parity = EVEN;
      2'b10:   c.parity = ODD;
      default: c.parity = NONE;
    endcase
    c.stop_bits = stop;
    return c;
  endfunction

endpackage

// File: rtl/uart_rx_core_baud_gen.sv
// Baud divisor counter with oversample tick and in-bit phase outputs.
// Ports: i_clk, i_rst_n, i_run (hold at reload when 0), i_div, o_tick, o_phase.
module uart_baud_gen #(
  parameter int DIV_WIDTH  = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_run,
  input  logic [DIV_WIDTH-1:0]          i_div,
  output logic                          o_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] o_phase
);

  localparam int PW = $clog2(OVERSAMPLE);
  localparam logic [PW-1:0] PH_MAX = PW'(OVERSAMPLE - 1);

  logic [DIV_WIDTH-1:0] r_cnt;
  logic [PW-1:0]        r_phase;

  assign o_tick  = i_run && (r_cnt == '0);
  assign o_phase = r_phase;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_phase <= '0;
    end else if (!i_run) begin
      r_cnt   <= i_div;
      r_phase <= '0;
    end else if (r_cnt == '0) begin
      r_cnt   <= i_div;
      r_phase <= (r_phase == PH_MAX) ? '0 : r_phase + 1'b1;
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// Configurable UART receiver: sync, 3-sample majority vote, frame FSM.
// Ports: clk/rst, en, rx line, config, data/sideband with valid/ready, pulses.
module uart_rx_core
  import uart_rx_core_pkg::*;
#(
  parameter int DATA_WIDTH_MAX = UART_DATA_WIDTH_MAX,
  parameter int OVERSAMPLE     = 16,
  parameter int DIV_WIDTH      = 16,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      en_i,
  input  logic                      rx_i,
  input  logic [DIV_WIDTH-1:0]      baud_div_i,
  input  logic [3:0]                data_bits_i,
  input  logic [1:0]                parity_mode_i,
  input  logic                      stop_bits_i,
  output logic [DATA_WIDTH_MAX-1:0] data_o,
  output logic                      parity_err_o,
  output logic                      frame_err_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic                      rx_done_o,
  output logic                      overflow_o,
  output logic                      busy_o
);

  localparam int PW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_WIDTH_MAX);
  localparam logic [PW-1:0] PH_S1  = PW'(OVERSAMPLE / 2 - 1);
  localparam logic [PW-1:0] PH_S2  = PW'(OVERSAMPLE / 2);
  localparam logic [PW-1:0] PH_S3  = PW'(OVERSAMPLE / 2 + 1);
  localparam logic [PW-1:0] PH_END = PW'(OVERSAMPLE - 1);

  logic [SYNC_STAGES-1:0]    r_sync;
  logic                      r_prev;
  uart_rx_state_e            r_state;
  uart_rx_cfg_t              r_cfg;
  logic [3:0]                r_bitcnt;
  logic                      r_stopcnt;
  logic                      r_s1, r_s2;
  logic                      r_par, r_perr, r_ferr;
  logic [DATA_WIDTH_MAX-1:0] r_shift;
  logic [DATA_WIDTH_MAX-1:0] r_data;
  logic                      r_perr_o, r_ferr_o;
  logic                      r_valid, r_done, r_ovf;

  logic          w_rx, w_fall, w_run;
  logic          w_tick, w_smp, w_end;
  logic          w_vote, w_ferr;
  logic [PW-1:0] w_phase;

  assign w_rx   = r_sync[SYNC_STAGES-1];
  assign w_fall = r_prev & ~w_rx;
  assign w_run  = (r_state != IDLE);
  // Third sample is the live line; the first two were captured earlier.
  assign w_vote = (r_s1 & r_s2) | (r_s1 & w_rx) | (r_s2 & w_rx);
  assign w_smp  = w_tick && (w_phase == PH_S3);
  assign w_end  = w_tick && (w_phase == PH_END);
  assign w_ferr = r_ferr | ~w_vote;

  uart_baud_gen #(
    .DIV_WIDTH (DIV_WIDTH),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_baud (
    .i_clk  (clk_i),
    .i_rst_n(rstn_i),
    .i_run  (w_run),
    .i_div  (baud_div_i),
    .o_tick (w_tick),
    .o_phase(w_phase)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_sync <= '1;
      r_prev <= 1'b1;
      r_s1   <= 1'b1;
      r_s2   <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rx_i};
      r_prev <= w_rx;
      if (w_tick && w_phase == PH_S1) r_s1 <= w_rx;
      if (w_tick && w_phase == PH_S2) r_s2 <= w_rx;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state   <= IDLE;
      r_cfg     <= '0;
      r_bitcnt  <= '0;
      r_stopcnt <= 1'b0;
      r_par     <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_shift   <= '0;
      r_data    <= '0;
      r_perr_o  <= 1'b0;
      r_ferr_o  <= 1'b0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
      if (r_valid && ready_i) r_valid <= 1'b0;
      if (!en_i) begin
        r_state <= IDLE;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (w_fall) begin
              r_state   <= START;
              r_cfg     <= cfg_clamp(data_bits_i, parity_mode_i,
                                     stop_bits_i, DATA_WIDTH_MAX);
              r_bitcnt  <= '0;
              r_stopcnt <= 1'b0;
              r_shift   <= '0;
              r_par     <= 1'b0;
              r_perr    <= 1'b0;
              r_ferr    <= 1'b0;
            end
          end
          START: begin
            if (w_smp && w_vote) r_state <= IDLE;
            else if (w_end)      r_state <= DATA;
          end
          DATA: begin
            if (w_smp) begin
              r_shift[r_bitcnt[IW-1:0]] <= w_vote;
              r_par <= r_par ^ w_vote;
            end
            if (w_end) begin
              r_bitcnt <= r_bitcnt + 4'd1;
              if (r_bitcnt == r_cfg.data_bits - 4'd1)
                r_state <= (r_cfg.parity == NONE) ? STOP : PARITY;
            end
          end
          PARITY: begin
            if (w_smp)
              r_perr <= (r_par ^ w_vote) != (r_cfg.parity == ODD);
            if (w_end) r_state <= STOP;
          end
          STOP: begin
            if (w_smp) begin
              if (r_stopcnt == r_cfg.stop_bits) begin
                r_done <= 1'b1;
                if (!r_valid || ready_i) begin
                  r_valid  <= 1'b1;
                  r_data   <= r_shift;
                  r_perr_o <= r_perr;
                  r_ferr_o <= w_ferr;
                end else begin
                  r_ovf <= 1'b1;
                end
                // A low line after a bad stop is a break; park until high.
                r_state <= (w_ferr && !w_rx) ? BREAK : IDLE;
              end else begin
                r_ferr <= w_ferr;
              end
            end
            if (w_end) r_stopcnt <= 1'b1;
          end
          BREAK: begin
            if (w_rx) r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign data_o       = r_data;
  assign parity_err_o = r_perr_o;
  assign frame_err_o  = r_ferr_o;
  assign valid_o      = r_valid;
  assign rx_done_o    = r_done;
  assign overflow_o   = r_ovf;
  assign busy_o       = (r_state != IDLE);

endmodule
